// File: rtl/proc_pkg.sv
// Shared core types for the writeback path: data/index widths, the writeback
// request bundle and the requester identifiers.
package proc_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wb_req_t;

  typedef enum logic {
    WB_LD  = 1'b0,
    WB_ALU = 1'b1
  } wb_src_e;

endpackage

// File: rtl/regfile_bypass.sv
// Forwards the write currently on the regfile port to a read port and forces
// reads of x0 to zero.
module regfile_bypass #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic [DATA_WIDTH-1:0] byp_data
);

  always_comb begin
    if ((rd_addr == w_addr) && (w_addr != '0)) begin
      byp_data = w_data;
    end else if (rd_addr == '0) begin
      byp_data = '0;
    end else begin
      byp_data = rd_data;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single regfile write port between the load unit and the ALU,
// with a starvation guard for the ALU, a one-cycle output register and bypass.
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH = proc_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = proc_pkg::ADDR_WIDTH,
  parameter int MAX_WAIT   = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  ld_valid_i,
  output logic                  ld_ready_o,
  input  logic [ADDR_WIDTH-1:0] ld_addr_i,
  input  logic [DATA_WIDTH-1:0] ld_data_i,
  input  logic                  alu_valid_i,
  output logic                  alu_ready_o,
  input  logic [ADDR_WIDTH-1:0] alu_addr_i,
  input  logic [DATA_WIDTH-1:0] alu_data_i,
  output logic [ADDR_WIDTH-1:0] w_addr_o,
  output logic [DATA_WIDTH-1:0] w_data_o,
  input  logic [ADDR_WIDTH-1:0] r1_addr_i,
  input  logic [ADDR_WIDTH-1:0] r2_addr_i,
  input  logic [DATA_WIDTH-1:0] r1_data_i,
  input  logic [DATA_WIDTH-1:0] r2_data_i,
  output logic [DATA_WIDTH-1:0] r1_data_o,
  output logic [DATA_WIDTH-1:0] r2_data_o,
  output logic                  alu_starved_o
);

  import proc_pkg::*;

  localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

  wb_req_t    ld_req;
  wb_req_t    alu_req;
  wb_req_t    win_req;
  wb_src_e    win_src;
  logic       grant_any;
  logic       starve_hit;
  logic [3:0] wait_cnt;

  assign ld_req  = '{valid: ld_valid_i,  addr: ld_addr_i,  data: ld_data_i};
  assign alu_req = '{valid: alu_valid_i, addr: alu_addr_i, data: alu_data_i};

  assign starve_hit    = (wait_cnt == MAX_CNT);
  assign alu_starved_o = ld_req.valid && alu_req.valid && starve_hit;

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    ld_ready_o  = 1'b0;
    alu_ready_o = 1'b0;
    win_src     = WB_LD;
    grant_any   = 1'b0;
    if (alu_req.valid && (!ld_req.valid || starve_hit)) begin
      alu_ready_o = 1'b1;
      win_src     = WB_ALU;
      grant_any   = 1'b1;
    end else if (ld_req.valid) begin
      ld_ready_o = 1'b1;
      grant_any  = 1'b1;
    end
  end

  assign win_req = (win_src == WB_ALU) ? alu_req : ld_req;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wait_cnt <= '0;
    end else if (alu_ready_o) begin
      wait_cnt <= '0;
    end else if (alu_req.valid && !starve_hit) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  // Idle cycles only drop the address; the data register keeps its last value.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      w_addr_o <= '0;
      w_data_o <= '0;
    end else if (grant_any) begin
      w_addr_o <= win_req.addr;
      w_data_o <= win_req.data;
    end else begin
      w_addr_o <= '0;
    end
  end

  regfile_bypass #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_bypass_r1 (
    .rd_addr (r1_addr_i),
    .rd_data (r1_data_i),
    .w_addr  (w_addr_o),
    .w_data  (w_data_o),
    .byp_data(r1_data_o)
  );

  regfile_bypass #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_bypass_r2 (
    .rd_addr (r2_addr_i),
    .rd_data (r2_data_i),
    .w_addr  (w_addr_o),
    .w_data  (w_data_o),
    .byp_data(r2_data_o)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and randomized checks of regfile_wb_arbiter against a cycle-level
// behavioural model of grants, starvation streak and the registered write.
module tb_regfile_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int MW = 3;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          ld_valid_i, alu_valid_i;
  logic          ld_ready_o, alu_ready_o, alu_starved_o;
  logic [AW-1:0] ld_addr_i, alu_addr_i, r1_addr_i, r2_addr_i, w_addr_o;
  logic [DW-1:0] ld_data_i, alu_data_i, r1_data_i, r2_data_i;
  logic [DW-1:0] w_data_o, r1_data_o, r2_data_o;

  regfile_wb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_WAIT(MW)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .ld_valid_i(ld_valid_i), .ld_ready_o(ld_ready_o),
    .ld_addr_i(ld_addr_i), .ld_data_i(ld_data_i),
    .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o),
    .alu_addr_i(alu_addr_i), .alu_data_i(alu_data_i),
    .w_addr_o(w_addr_o), .w_data_o(w_data_o),
    .r1_addr_i(r1_addr_i), .r2_addr_i(r2_addr_i),
    .r1_data_i(r1_data_i), .r2_data_i(r2_data_i),
    .r1_data_o(r1_data_o), .r2_data_o(r2_data_o),
    .alu_starved_o(alu_starved_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Reference state: how many cycles the ALU has been refused, and what the
  // regfile port should show after the most recent edge.
  int            streak;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  bit            g_ld, g_alu;
  bit            grants[$];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] read_view(input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (m_waddr != 0 && a == m_waddr) return m_wdata;
    if (a == 0) return '0;
    return d;
  endfunction

  task automatic model_reset();
    streak  = 0;
    m_waddr = '0;
    m_wdata = '0;
  endtask

  // One clock: combinational checks mid-cycle, registered checks after the edge.
  task automatic step();
    @(negedge clk_i);
    g_alu = alu_valid_i && (!ld_valid_i || streak == MW);
    g_ld  = ld_valid_i && !g_alu;
    chk("ld_ready",  ld_ready_o,  g_ld);
    chk("alu_ready", alu_ready_o, g_alu);
    chk("starved",   alu_starved_o, ld_valid_i && alu_valid_i && streak == MW);
    chk("r1_data",   r1_data_o, read_view(r1_addr_i, r1_data_i));
    chk("r2_data",   r2_data_o, read_view(r2_addr_i, r2_data_i));
    @(posedge clk_i);
    #1;
    if (g_ld) begin
      m_waddr = ld_addr_i;  m_wdata = ld_data_i;
    end else if (g_alu) begin
      m_waddr = alu_addr_i; m_wdata = alu_data_i;
    end else begin
      m_waddr = '0;
    end
    if (g_alu) streak = 0;
    else if (alu_valid_i) streak = (streak + 1 > MW) ? MW : streak + 1;
    grants.push_back(g_alu);
    chk("w_addr", w_addr_o, m_waddr);
    chk("w_data", w_data_o, m_wdata);
  endtask

  initial begin
    rst_n_i = 1'b0;
    ld_valid_i = 0;  ld_addr_i = '0;  ld_data_i = '0;
    alu_valid_i = 0; alu_addr_i = '0; alu_data_i = '0;
    r1_addr_i = '0;  r2_addr_i = '0;  r1_data_i = '0; r2_data_i = '0;
    model_reset();

    // Reset, then idle
    #3;
    chk("rst_w_addr", w_addr_o, '0);
    chk("rst_w_data", w_data_o, '0);
    chk("rst_starved", alu_starved_o, 1'b0);
    #9 rst_n_i = 1'b1;
    #4;
    step();

    // Single ALU write x5 = 0x1234
    alu_valid_i = 1; alu_addr_i = 5; alu_data_i = 32'h1234;
    step();
    chk("alu_w_addr", w_addr_o, 5);
    chk("alu_w_data", w_data_o, 32'h1234);
    alu_valid_i = 0;
    step();
    chk("alu_idle", w_addr_o, 0);

    // Contention: both valid continuously
    grants.delete();
    ld_valid_i = 1;  ld_addr_i = 10;  ld_data_i = 32'hAAAA;
    alu_valid_i = 1; alu_addr_i = 11; alu_data_i = 32'hBBBB;
    repeat (5) step();
    chk("cont_g0", grants[0], 0);
    chk("cont_g1", grants[1], 0);
    chk("cont_g2", grants[2], 0);
    chk("cont_g3", grants[3], 1);
    chk("cont_g4", grants[4], 0);
    ld_valid_i = 0; alu_valid_i = 0;
    step();

    // Bypass on an in-flight write
    ld_valid_i = 1; ld_addr_i = 4; ld_data_i = 32'hDEAD;
    step();
    ld_valid_i = 0;
    r1_addr_i = 4; r2_addr_i = 6; r1_data_i = 32'h55; r2_data_i = 32'h8;
    #2;
    chk("byp_r1", r1_data_o, 32'hDEAD);
    chk("byp_r2", r2_data_o, 32'h8);
    r1_addr_i = 0;
    #1;
    chk("byp_r1_x0", r1_data_o, 0);
    step();

    // x0 write consumes the slot but presents no address
    ld_valid_i = 1; ld_addr_i = 0; ld_data_i = 32'hFFFF;
    step();
    chk("x0_w_addr", w_addr_o, 0);
    r1_addr_i = 0; r1_data_i = 32'h1357;
    #1;
    chk("x0_r1", r1_data_o, 0);
    ld_valid_i = 0;
    step();

    // Async reset while a write to x7 is on the port
    ld_valid_i = 1; ld_addr_i = 7; ld_data_i = 32'h77;
    alu_valid_i = 1; alu_addr_i = 8; alu_data_i = 32'h88;
    step();
    chk("pre_rst_w_addr", w_addr_o, 7);
    ld_valid_i = 0; alu_valid_i = 0;
    #2 rst_n_i = 1'b0;
    #1;
    chk("async_w_addr", w_addr_o, 0);
    model_reset();
    #2 rst_n_i = 1'b1;
    alu_valid_i = 1; alu_addr_i = 9; alu_data_i = 32'h99;
    step();
    chk("post_rst_w_addr", w_addr_o, 9);
    alu_valid_i = 0;

    // Randomized traffic; a refused requester holds its request
    for (int i = 0; i < 400; i++) begin
      if (!(ld_valid_i && !g_ld)) begin
        ld_valid_i = ($urandom_range(0, 3) != 0);
        ld_addr_i  = AW'($urandom);
        ld_data_i  = $urandom;
      end
      if (!(alu_valid_i && !g_alu)) begin
        alu_valid_i = ($urandom_range(0, 2) != 0);
        alu_addr_i  = AW'($urandom);
        alu_data_i  = $urandom;
      end
      r1_addr_i = ($urandom_range(0, 1) != 0) ? m_waddr : AW'($urandom);
      r2_addr_i = AW'($urandom);
      r1_data_i = $urandom;
      r2_data_i = $urandom;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters: load unit (req 0) and ALU (req 1).
- Arbitrates with fixed priority to the load unit. A starvation guard forces an ALU grant after MAX_WAIT consecutive denied cycles.
- Registers the winning write for one cycle, then drives the regfile write port (addr 0 = no write).
- Provides same-cycle bypass for both regfile read ports, covering the write in flight during the current cycle.

Parameters:
- DATA_WIDTH, 32, width of register data (matches core DATA_WIDTH define)
- ADDR_WIDTH, 5, register index width (32 architectural regs, x0 hardwired zero)
- MAX_WAIT, 3, consecutive denied ALU-valid cycles before ALU priority is forced; legal range 1..15

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous, active-low
- ld_valid_i  in  1  load writeback request
- ld_ready_o  out  1  load request accepted this cycle
- ld_addr_i  in  ADDR_WIDTH  load destination register
- ld_data_i  in  DATA_WIDTH  load result
- alu_valid_i  in  1  ALU writeback request
- alu_ready_o  out  1  ALU request accepted this cycle
- alu_addr_i  in  ADDR_WIDTH  ALU destination register
- alu_data_i  in  DATA_WIDTH  ALU result
- w_addr_o  out  ADDR_WIDTH  regfile write address (0 = idle)
- w_data_o  out  DATA_WIDTH  regfile write data
- r1_addr_i  in  ADDR_WIDTH  regfile read port 1 address (snooped)
- r2_addr_i  in  ADDR_WIDTH  regfile read port 2 address (snooped)
- r1_data_i  in  DATA_WIDTH  regfile read port 1 data
- r2_data_i  in  DATA_WIDTH  regfile read port 2 data
- r1_data_o  out  DATA_WIDTH  bypassed read data 1
- r2_data_o  out  DATA_WIDTH  bypassed read data 2
- alu_starved_o  out  1  starvation guard active this cycle

Behaviour:
- Reset (async): w_addr_o=0, w_data_o=0, wait counter=0. Consequently alu_starved_o=0, and ready outputs follow the combinational rules below.
- Handshake: transfer occurs when valid && ready. ready is combinational from the valid inputs and the wait counter. Requesters must hold addr/data stable while valid && !ready. At most one ready is high per cycle.
- Grant rules:
  - Only one valid: grant it.
  - Both valid: grant load, unless wait counter == MAX_WAIT; then grant ALU and assert alu_starved_o.
  - Neither valid: no grant.
- Wait counter:
  - Increments each cycle alu_valid_i && !alu_ready_o, saturating at MAX_WAIT.
  - Clears on an ALU transfer.
  - Holds when alu_valid_i=0.
- Output stage, at each edge:
  - Transfer: w_addr_o/w_data_o <= granted addr/data.
  - No transfer: w_addr_o <= 0; w_data_o holds its previous value.
- Latency: accepted at edge N; presented to regfile during cycle N+1; architecturally written at edge N+1.
- x0 writes: accepted like any request and consume the slot. w_addr_o=0, so the regfile ignores the write.
- Bypass (combinational):
  - rK_data_o = w_data_o if rK_addr_i == w_addr_o and w_addr_o != 0.
  - Else rK_data_o = 0 if rK_addr_i == 0.
  - Else rK_data_o = rK_data_i.
  - Both read ports are bypassed independently.
- Both requesters targeting the same register in one cycle: serialised by the grant rules; the later write wins in the regfile.
- Reset asserted mid-operation: in-flight registered write is dropped (w_addr_o->0 immediately); counter clears.

Decomposition:
- Shared package (proc_pkg):
  - DATA_WIDTH/ADDR_WIDTH constants
  - wb_req_t struct {valid, addr, data}
  - requester index enum {WB_LD, WB_ALU}
- One sub-module, regfile_bypass: purely combinational compare/mux. Instantiated twice, once per read port.
- Arbiter, wait counter and output register stay in the top module.

Test Plan:
- Reset then idle: w_addr_o=0, both ready high only when own valid high, alu_starved_o=0.
- Single ALU write x5=0x1234 at edge N: alu_ready_o=1 in that cycle; w_addr_o=5, w_data_o=0x1234 in cycle N+1; w_addr_o=0 in cycle N+2.
- Contention, both valid continuously, MAX_WAIT=3:
  - Grant sequence LD, LD, LD, then ALU with alu_starved_o=1, then LD.
  - Counter clears after the ALU grant.
- Bypass: w_addr_o=4/w_data_o=0xDEAD, r1_addr_i=4, r2_addr_i=6, r2_data_i=0x8 -> r1_data_o=0xDEAD, r2_data_o=0x8. Same check with r1_addr_i=0 -> r1_data_o=0.
- x0 request, ld addr=0, data=0xFFFF: accepted; w_addr_o=0 next cycle; r1_addr_i=0 still returns 0.
- Async reset asserted while w_addr_o=7: w_addr_o=0 immediately without a clock edge; first request after release is granted normally.
